// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Shared MEM-stage bus widths, EXE->MEM field offsets and encodings.
// Rev    : 1.0
// ============================================================================
package mem_pkg;

   localparam int c_exe_mem_w = 159;
   localparam int c_mem_wb_w  = 156;

   // LSB position of each EXE->MEM field
   localparam int c_f_load    = 158;
   localparam int c_f_store   = 157;
   localparam int c_f_size    = 155;
   localparam int c_f_signed  = 154;
   localparam int c_f_sdata   = 122;
   localparam int c_f_exe     = 90;
   localparam int c_f_lo      = 58;
   localparam int c_f_ctrl    = 52;   // hi_write, lo_write, mfhi, mflo, mtc0, mfc0
   localparam int c_f_cp0r    = 44;
   localparam int c_f_wen     = 43;
   localparam int c_f_wdest   = 38;
   localparam int c_f_syscall = 37;
   localparam int c_f_eret    = 36;
   localparam int c_f_break   = 35;
   localparam int c_f_fetch   = 34;
   localparam int c_f_rsv     = 33;
   localparam int c_f_ovf     = 32;
   localparam int c_f_pc      = 0;

   typedef enum logic [1:0] {
      LS_BYTE = 2'b00,
      LS_HALF = 2'b01,
      LS_WORD = 2'b10
   } ls_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_HOLD   = 2'b10
   } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module : mem_align
// Store lane enables/replication, misalignment flags, load extract/extend.
// Rev    : 1.0
// ============================================================================
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_ls_size,
   input  logic        i_ls_signed,
   input  logic        i_inst_load,
   input  logic        i_inst_store,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wen,
   output logic [31:0] o_wdata,
   output logic        o_raddr_error,
   output logic        o_waddr_error,
   output logic [31:0] o_load_value
);

   logic        w_misaligned;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_misaligned = 1'b0;
      o_wen        = 4'b1111;
      o_wdata      = i_store_data;
      o_load_value = i_rdata;
      case (i_ls_size)
         LS_BYTE: begin
            o_wen        = 4'b0001 << i_addr;
            o_wdata      = {4{i_store_data[7:0]}};
            o_load_value = {{24{i_ls_signed & w_byte[7]}}, w_byte};
         end
         LS_HALF: begin
            w_misaligned = i_addr[0];
            o_wen        = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_store_data[15:0]}};
            o_load_value = {{16{i_ls_signed & w_half[15]}}, w_half};
         end
         default: begin
            w_misaligned = |i_addr;
         end
      endcase
   end

   assign o_raddr_error = i_inst_load  & w_misaligned;
   assign o_waddr_error = i_inst_store & w_misaligned;

endmodule
`default_nettype wire

// File: rtl/mem.sv
`default_nettype none
// ============================================================================
// Module : mem
// MIPS MEM stage: data-RAM access FSM, load capture and MEM->WB bus packing.
// Rev    : 1.0
// ============================================================================
module mem
   import mem_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MEM_valid,
   input  logic [c_exe_mem_w-1:0] EXE_MEM_bus_r,
   input  logic                   WB_allow_in,
   input  logic                   cancel,
   input  logic [31:0]            dm_rdata,
   output logic                   dm_en,
   output logic [3:0]             dm_wen,
   output logic [31:0]            dm_addr,
   output logic [31:0]            dm_wdata,
   output logic                   MEM_over,
   output logic [c_mem_wb_w-1:0]  MEM_WB_bus,
   output logic [4:0]             MEM_wdest,
   output logic [31:0]            MEM_pc
);

   logic        w_inst_load, w_inst_store, w_ls_signed, w_wen;
   logic [1:0]  w_ls_size;
   logic [31:0] w_store_data, w_exe_result, w_lo_result, w_pc;
   logic [5:0]  w_ctrl;
   logic [7:0]  w_cp0r_addr;
   logic [4:0]  w_wdest;
   logic        w_syscall, w_eret, w_brk, w_fetch_error, w_inst_reserved, w_overflow;

   assign w_inst_load     = EXE_MEM_bus_r[c_f_load];
   assign w_inst_store    = EXE_MEM_bus_r[c_f_store];
   assign w_ls_size       = EXE_MEM_bus_r[c_f_size +: 2];
   assign w_ls_signed     = EXE_MEM_bus_r[c_f_signed];
   assign w_store_data    = EXE_MEM_bus_r[c_f_sdata +: 32];
   assign w_exe_result    = EXE_MEM_bus_r[c_f_exe +: 32];
   assign w_lo_result     = EXE_MEM_bus_r[c_f_lo +: 32];
   assign w_ctrl          = EXE_MEM_bus_r[c_f_ctrl +: 6];
   assign w_cp0r_addr     = EXE_MEM_bus_r[c_f_cp0r +: 8];
   assign w_wen           = EXE_MEM_bus_r[c_f_wen];
   assign w_wdest         = EXE_MEM_bus_r[c_f_wdest +: 5];
   assign w_syscall       = EXE_MEM_bus_r[c_f_syscall];
   assign w_eret          = EXE_MEM_bus_r[c_f_eret];
   assign w_brk           = EXE_MEM_bus_r[c_f_break];
   assign w_fetch_error   = EXE_MEM_bus_r[c_f_fetch];
   assign w_inst_reserved = EXE_MEM_bus_r[c_f_rsv];
   assign w_overflow      = EXE_MEM_bus_r[c_f_ovf];
   assign w_pc            = EXE_MEM_bus_r[c_f_pc +: 32];

   state_e      r_state, w_state_nxt;
   logic [31:0] r_load;
   logic [31:0] w_raw_data, w_load_value, w_wdata, w_mem_result;
   logic [3:0]  w_lanes;
   logic        w_raddr_error, w_waddr_error;
   logic        w_mem_op, w_active, w_issue, w_over;

   // HOLD never re-reads the RAM; its data comes only from the captured word
   assign w_raw_data = (r_state == ST_ACCESS) ? dm_rdata : r_load;

   mem_align u_align (
      .i_ls_size     (w_ls_size),
      .i_ls_signed   (w_ls_signed),
      .i_inst_load   (w_inst_load),
      .i_inst_store  (w_inst_store),
      .i_addr        (w_exe_result[1:0]),
      .i_store_data  (w_store_data),
      .i_rdata       (w_raw_data),
      .o_wen         (w_lanes),
      .o_wdata       (w_wdata),
      .o_raddr_error (w_raddr_error),
      .o_waddr_error (w_waddr_error),
      .o_load_value  (w_load_value)
   );

   assign w_mem_op = (w_inst_load | w_inst_store)
                   & ~(w_syscall | w_brk | w_fetch_error | w_inst_reserved | w_overflow)
                   & ~(w_raddr_error | w_waddr_error);
   assign w_active = MEM_valid & ~cancel;
   assign w_issue  = w_active & w_mem_op & (r_state == ST_IDLE) & ~reset;

   assign dm_en    = w_issue;
   assign dm_wen   = (w_issue & w_inst_store) ? w_lanes : 4'b0000;
   assign dm_addr  = {w_exe_result[31:2], 2'b00};
   assign dm_wdata = w_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load <= 32'h0;
      end else if (r_state == ST_ACCESS) begin
         r_load <= dm_rdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_over      = 1'b0;
      if (w_active) begin
         if (!w_mem_op)         w_over = 1'b1;
         else if (w_inst_store) w_over = (r_state != ST_ACCESS);
         else                   w_over = (r_state != ST_IDLE);
      end
      if (cancel) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue & w_inst_load)                     w_state_nxt = ST_ACCESS;
               else if (w_issue & w_inst_store & ~WB_allow_in) w_state_nxt = ST_HOLD;
            end
            ST_ACCESS: w_state_nxt = WB_allow_in ? ST_IDLE : ST_HOLD;
            ST_HOLD:   if (WB_allow_in) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign MEM_over     = w_over;
   assign w_mem_result = (w_inst_load & w_mem_op & (r_state != ST_IDLE)) ? w_load_value
                                                                          : w_exe_result;

   assign MEM_WB_bus = {w_wen, w_wdest, w_mem_result, w_lo_result, w_ctrl, w_cp0r_addr,
                        w_syscall, w_eret, w_brk, w_fetch_error, w_inst_reserved,
                        w_raddr_error, w_waddr_error, w_overflow, w_exe_result, w_pc};
   assign MEM_wdest  = w_wdest & {5{MEM_valid}};
   assign MEM_pc     = w_pc;

endmodule
`default_nettype wire

// File: tb/tb_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mem
// Randomised bench for the MEM stage against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_mem;

   logic         clk;
   logic         reset;
   logic         MEM_valid;
   logic [158:0] EXE_MEM_bus_r;
   logic         WB_allow_in;
   logic         cancel;
   logic [31:0]  dm_rdata;
   logic         dm_en;
   logic [3:0]   dm_wen;
   logic [31:0]  dm_addr;
   logic [31:0]  dm_wdata;
   logic         MEM_over;
   logic [155:0] MEM_WB_bus;
   logic [4:0]   MEM_wdest;
   logic [31:0]  MEM_pc;

   mem dut (
      .clk           (clk),
      .reset         (reset),
      .MEM_valid     (MEM_valid),
      .EXE_MEM_bus_r (EXE_MEM_bus_r),
      .WB_allow_in   (WB_allow_in),
      .cancel        (cancel),
      .dm_rdata      (dm_rdata),
      .dm_en         (dm_en),
      .dm_wen        (dm_wen),
      .dm_addr       (dm_addr),
      .dm_wdata      (dm_wdata),
      .MEM_over      (MEM_over),
      .MEM_WB_bus    (MEM_WB_bus),
      .MEM_wdest     (MEM_wdest),
      .MEM_pc        (MEM_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction currently presented to the stage
   logic        t_load, t_store, t_signed, t_wen;
   logic [1:0]  t_size;
   logic [31:0] t_sdata, t_addr, t_lo, t_pc;
   logic [5:0]  t_ctrl, t_exc;   // t_exc = {syscall, eret, break, fetch_error, reserved, overflow}
   logic [7:0]  t_cp0;
   logic [4:0]  t_wdest;

   logic [31:0] model_mem [16];
   logic        issued;
   logic [31:0] held;
   logic        need_new;
   int          checks;
   int          errors;
   logic        obs_en, obs_over;
   logic [3:0]  obs_wen;
   logic [155:0] obs_bus;
   int          wcount;

   // synchronous RAM; unread cycles return noise so stale dm_rdata use is visible
   logic        ram_clr;
   logic [31:0] ram [16];

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
   endfunction

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
         dm_rdata <= 32'h0;
      end else if (dm_en) begin
         for (int b = 0; b < 4; b++)
            if (dm_wen[b]) ram[dm_addr[5:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
         dm_rdata <= ram[dm_addr[5:2]];
      end else begin
         dm_rdata <= $urandom;
      end
   end

   function automatic int acc_bytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
      return (int'(a) % acc_bytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
      int n = acc_bytes(sz);
      int first = int'(a) - (int'(a) % n);
      logic [3:0] m = 4'b0000;
      for (int b = 0; b < 4; b++) if (b >= first && b < first + n) m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] repl_data(input logic [1:0] sz, input logic [31:0] sd);
      int n = acc_bytes(sz);
      logic [31:0] r = 32'h0;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = sd[8*(b % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] a);
      int n = acc_bytes(sz);
      int first = int'(a) - (int'(a) % n);
      logic [31:0] v = word >> (8 * first);
      if (n == 4) return word;
      if (n == 1) begin
         v = v & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = v & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [155:0] act, input logic [155:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a falling edge with inputs set; compares, crosses the
   // rising edge, advances the model and returns at the next falling edge.
   task automatic cycle();
      logic mis, rerr, werr, fault, memop, active, een, eover;
      logic [3:0] ewen;
      logic [31:0] eres, wd;
      logic [155:0] ebus;
      EXE_MEM_bus_r = {t_load, t_store, t_size, t_signed, t_sdata, t_addr, t_lo, t_ctrl,
                       t_cp0, t_wen, t_wdest, t_exc, t_pc};
      #1;
      if (reset) issued = 1'b0;
      mis    = misal(t_size, t_addr[1:0]);
      rerr   = t_load & mis;
      werr   = t_store & mis;
      fault  = t_exc[5] | t_exc[3] | t_exc[2] | t_exc[1] | t_exc[0] | rerr | werr;
      memop  = (t_load | t_store) & ~fault;
      active = MEM_valid & ~cancel;
      een    = active & memop & ~issued & ~reset;
      ewen   = (een & t_store) ? lane_mask(t_size, t_addr[1:0]) : 4'b0000;
      eover  = active & (~memop | t_store | issued);
      eres   = (t_load & memop & issued) ? held : t_addr;
      wd     = repl_data(t_size, t_sdata);
      ebus   = {t_wen, t_wdest, eres, t_lo, t_ctrl, t_cp0, t_exc[5], t_exc[4], t_exc[3],
                t_exc[2], t_exc[1], rerr, werr, t_exc[0], t_addr, t_pc};

      chk("dm_en", 156'(dm_en), 156'(een));
      chk("dm_wen", 156'(dm_wen), 156'(ewen));
      if (MEM_valid) chk("dm_addr", 156'(dm_addr), 156'({t_addr[31:2], 2'b00}));
      if (ewen != 4'b0000) chk("dm_wdata", 156'(dm_wdata), 156'(wd));
      chk("MEM_over", 156'(MEM_over), 156'(eover));
      chk("MEM_wdest", 156'(MEM_wdest), 156'(MEM_valid ? t_wdest : 5'd0));
      chk("MEM_pc", 156'(MEM_pc), 156'(t_pc));
      if (eover) chk("MEM_WB_bus", MEM_WB_bus, ebus);
      obs_en   = dm_en;
      obs_wen  = dm_wen;
      obs_over = MEM_over;
      obs_bus  = MEM_WB_bus;

      @(posedge clk);
      if (ewen != 4'b0000)
         for (int b = 0; b < 4; b++)
            if (ewen[b]) model_mem[t_addr[5:2]][8*b +: 8] = wd[8*b +: 8];
      if (reset || cancel) issued = 1'b0;
      else if (eover && WB_allow_in) issued = 1'b0;
      else if (een) begin
         issued = 1'b1;
         held   = ext_load(model_mem[t_addr[5:2]], t_size, t_signed, t_addr[1:0]);
      end
      need_new = ~MEM_valid | cancel | (eover & WB_allow_in);
      @(negedge clk);
   endtask

   task automatic set_instr(input logic ld, input logic st, input logic [1:0] sz,
                            input logic sg, input logic [31:0] sd, input logic [31:0] addr);
      t_load = ld;  t_store = st;  t_size = sz;  t_signed = sg;
      t_sdata = sd; t_addr = addr;
      t_lo = 32'h1111_2222; t_ctrl = 6'b100101; t_cp0 = 8'h3C;
      t_wen = ld; t_wdest = 5'd9; t_exc = 6'b000000;
      t_pc = 32'hBFC0_0000 + addr;
      MEM_valid = 1'b1;
   endtask

   task automatic new_instr();
      int kind;
      MEM_valid = ($urandom_range(0, 9) != 0);
      kind      = $urandom_range(0, 9);
      t_load    = (kind < 4);
      t_store   = (kind >= 4 && kind < 7);
      t_size    = 2'($urandom_range(0, 2));
      t_signed  = 1'($urandom_range(0, 1));
      t_sdata   = $urandom;
      t_addr    = 32'h100 + 32'($urandom_range(0, 63));
      t_lo      = $urandom;
      t_ctrl    = 6'($urandom);
      t_cp0     = 8'($urandom);
      t_wen     = 1'($urandom_range(0, 1));
      t_wdest   = 5'($urandom);
      t_exc     = ($urandom_range(0, 7) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      t_pc      = $urandom;
   endtask

   initial begin
      checks = 0; errors = 0;
      issued = 1'b0; held = 32'h0; need_new = 1'b1;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      reset = 1'b1; ram_clr = 1'b1;
      MEM_valid = 1'b0; cancel = 1'b0; WB_allow_in = 1'b0;
      set_instr(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h120);
      MEM_valid = 1'b0;
      @(negedge clk);

      // reset state
      cycle();
      chk("rst_over_idle", 156'(obs_over), 156'(1'b0));
      chk("rst_en_idle", 156'(obs_en), 156'(1'b0));
      MEM_valid = 1'b1;
      cycle();
      chk("rst_over_nonmem", 156'(obs_over), 156'(1'b1));
      reset = 1'b0; ram_clr = 1'b0; MEM_valid = 1'b0;
      cycle();

      // sw 0x12345678 @ 0x100
      set_instr(1'b0, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 32'h100);
      WB_allow_in = 1'b1;
      cycle();
      chk("sw_wen", 156'(obs_wen), 156'(4'b1111));
      chk("sw_over", 156'(obs_over), 156'(1'b1));
      set_instr(1'b0, 1'b1, 2'b10, 1'b0, 32'h80FF_FF7F, 32'h100);
      cycle();

      // lb / lbu @ 0x103
      set_instr(1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h103);
      cycle();
      chk("lb_issue_en", 156'(obs_en), 156'(1'b1));
      chk("lb_issue_over", 156'(obs_over), 156'(1'b0));
      cycle();
      chk("lb_over", 156'(obs_over), 156'(1'b1));
      chk("lb_result", 156'(obs_bus[149:118]), 156'(32'hFFFF_FF80));
      set_instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h103);
      cycle();
      cycle();
      chk("lbu_result", 156'(obs_bus[149:118]), 156'(32'h0000_0080));

      // sh @ 0x102 stalled three cycles
      set_instr(1'b0, 1'b1, 2'b01, 1'b0, 32'hCAFE_BEEF, 32'h102);
      WB_allow_in = 1'b0;
      wcount = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (obs_wen != 4'b0000) begin
            wcount++;
            chk("sh_wen", 156'(obs_wen), 156'(4'b1100));
         end
         chk("sh_hold_over", 156'(obs_over), 156'(1'b1));
      end
      WB_allow_in = 1'b1;
      cycle();
      if (obs_wen != 4'b0000) wcount++;
      chk("sh_write_once", 156'(wcount), 156'(1));

      // misaligned lw @ 0x101
      set_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h101);
      cycle();
      chk("lw_mis_en", 156'(obs_en), 156'(1'b0));
      chk("lw_mis_over", 156'(obs_over), 156'(1'b1));
      chk("lw_mis_raddr_err", 156'(obs_bus[66]), 156'(1'b1));
      chk("lw_mis_addr", 156'(obs_bus[63:32]), 156'(32'h101));

      // cancel while the load is in flight
      set_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h104);
      cycle();
      cancel = 1'b1;
      cycle();
      chk("cancel_over", 156'(obs_over), 156'(1'b0));
      cancel = 1'b0; MEM_valid = 1'b0;
      cycle();
      chk("cancel_no_en", 156'(obs_en), 156'(1'b0));

      // reset during a stalled store
      set_instr(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 32'h106);
      WB_allow_in = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      chk("rst_hold_wen", 156'(obs_wen), 156'(4'b0000));
      chk("rst_load_r", 156'(dut.r_load), 156'(32'h0));
      reset = 1'b0; WB_allow_in = 1'b1;
      cycle();
      chk("rst_reissue_wen", 156'(obs_wen), 156'(4'b1100));

      // randomised traffic
      MEM_valid = 1'b0; need_new = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (need_new) new_instr();
         WB_allow_in = ($urandom_range(0, 9) < 7);
         cancel      = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
